// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: pixel clock enable, h/v position counters with phase FSMs,
// registered syncs, display enable and line/frame strobes, all aligned to the new position.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int CLK_DIV  = 2
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_ce,
  output logic       h_sync,
  output logic       v_sync,
  output logic       de,
  output logic [9:0] h_pos,
  output logic [9:0] v_pos,
  output logic       line_start,
  output logic       frame_start
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] H_FP_AT  = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYN_AT = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_BP_AT  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] V_FP_AT  = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYN_AT = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_BP_AT  = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {ST_ACT, ST_FP, ST_SYN, ST_BP} phase_t;

  phase_t           h_st, h_st_nxt, v_st, v_st_nxt;
  logic [DIV_W-1:0] div;
  logic [9:0]       h_nxt, v_nxt;
  logic             h_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div    <= '0;
      pix_ce <= 1'b0;
    end else begin
      pix_ce <= (div == DIV_MAX);
      div    <= (div == DIV_MAX) ? '0 : div + 1'b1;
    end
  end

  always_comb begin
    h_wrap = pix_ce && (h_pos == H_LAST);
    h_nxt  = h_pos;
    v_nxt  = v_pos;
    if (pix_ce) h_nxt = h_wrap ? 10'd0 : h_pos + 10'd1;
    if (h_wrap) v_nxt = (v_pos == V_LAST) ? 10'd0 : v_pos + 10'd1;
  end

  // Phases are decoded from the next position so outputs land with the counters.
  always_comb begin
    h_st_nxt = h_st;
    v_st_nxt = v_st;
    if (pix_ce) begin
      if      (h_nxt == H_BP_AT)  h_st_nxt = ST_BP;
      else if (h_nxt == H_SYN_AT) h_st_nxt = ST_SYN;
      else if (h_nxt == H_FP_AT)  h_st_nxt = ST_FP;
      else if (h_nxt == 10'd0)    h_st_nxt = ST_ACT;
    end
    if (h_wrap) begin
      if      (v_nxt == V_BP_AT)  v_st_nxt = ST_BP;
      else if (v_nxt == V_SYN_AT) v_st_nxt = ST_SYN;
      else if (v_nxt == V_FP_AT)  v_st_nxt = ST_FP;
      else if (v_nxt == 10'd0)    v_st_nxt = ST_ACT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_st <= ST_BP;
      v_st <= ST_BP;
    end else begin
      h_st <= h_st_nxt;
      v_st <= v_st_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_pos       <= H_LAST;
      v_pos       <= V_LAST;
      h_sync      <= ~SYNC_POL;
      v_sync      <= ~SYNC_POL;
      de          <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_ce) begin
      h_pos       <= h_nxt;
      v_pos       <= v_nxt;
      h_sync      <= (h_st_nxt == ST_SYN) ? SYNC_POL : ~SYNC_POL;
      v_sync      <= (v_st_nxt == ST_SYN) ? SYNC_POL : ~SYNC_POL;
      de          <= (h_st_nxt == ST_ACT) && (v_st_nxt == ST_ACT);
      line_start  <= (h_nxt == 10'd0);
      frame_start <= (h_nxt == 10'd0) && (v_nxt == 10'd0);
    end
  end

endmodule
